result_uart_tx: RTL

- Downstream stage of the trial/evaluation block. Consumes the 8-bit return value the trial block produces and serialises it as a UART 8N1 frame on a single tx pin, so results can be read off the FPGA board.
- Provides a one-entry pending buffer, so one result can be queued while a frame is in flight.
- Trigger is either an explicit valid strobe or automatic send-on-change of the result bus, chosen by parameter.

---
 rtl/esfa_uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/result_uart_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/esfa_uart_pkg.sv
// Shared types and constants for the result UART transmitter.
// The frame is 8N1: one start bit, eight data bits sent LSB first, one stop bit.
package esfa_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = 8;

    // Counter width for a divider that counts 0..clks-1 (never narrower than 1 bit).
    function automatic int baud_cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and restarts on load.
// tick marks the last cycle of a bit period; pre_tick marks the cycle before it.
module uart_baud_tick
    import esfa_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Wrap exactly at the period boundary so consecutive bits never drift.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en) begin
            if (count == CNT_LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_ONE;
            end
        end
    end

    assign tick     = en && (count == CNT_LAST);
    assign pre_tick = en && (count == CNT_PRE_LAST);

endmodule

// File: rtl/result_uart_tx.sv
// Serialises 8-bit trial results as UART 8N1 frames, with a one-entry pending slot
// so a new result can be queued while the current frame is still shifting out.
//
// state | meaning
// IDLE  | line at idle level, waiting for the pending slot to fill
// START | driving the start bit (inverse of idle level)
// DATA  | driving shift_reg[bit_idx], LSB first
// STOP  | driving the stop bit; last cycle pulses tx_done
module result_uart_tx
    import esfa_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter bit SEND_ON_CHANGE = 1'b0,
    parameter bit IDLE_LEVEL     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [7:0] frame_count
);

    uart_state_t state;

    logic       pending_full;
    logic [7:0] pending_data;
    logic [7:0] last_accepted;
    logic       primed;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;

    logic trigger;
    logic accept;
    logic baud_load;
    logic baud_tick;
    logic baud_pre_tick;

    // Send-on-change also fires once after reset so the current value is reported.
    assign trigger     = SEND_ON_CHANGE ? (!primed || (result_in != last_accepted))
                                        : result_valid;
    assign ready       = !pending_full;
    assign accept      = trigger && !pending_full;
    assign baud_load   = (state == IDLE) && pending_full;
    assign bit_idx_nxt = bit_idx + 3'd1;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (baud_load),
        .en       (busy),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending_full  <= 1'b0;
            pending_data  <= '0;
            last_accepted <= '0;
            primed        <= 1'b0;
            shift_reg     <= '0;
            bit_idx       <= '0;
            tx            <= IDLE_LEVEL;
            busy          <= 1'b0;
            tx_done       <= 1'b0;
            frame_count   <= '0;
        end else begin
            tx_done <= 1'b0;

            // Accept needs an empty slot, so it can never coincide with the slot being drained.
            if (accept) begin
                pending_data  <= result_in;
                pending_full  <= 1'b1;
                last_accepted <= result_in;
                primed        <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending_full) begin
                        shift_reg    <= pending_data;
                        pending_full <= 1'b0;
                        state        <= START;
                        tx           <= ~IDLE_LEVEL;
                        busy         <= 1'b1;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= IDLE_LEVEL;
                        end else begin
                            bit_idx <= bit_idx_nxt;
                            tx      <= shift_reg[bit_idx_nxt];
                        end
                    end
                end

                STOP: begin
                    // pre_tick lines tx_done up with the final stop-bit cycle.
                    if (baud_pre_tick) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_tick) begin
                        frame_count <= frame_count + 8'd1;
                        if (pending_full) begin
                            shift_reg    <= pending_data;
                            pending_full <= 1'b0;
                            state        <= START;
                            tx           <= ~IDLE_LEVEL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
